// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
//   resp_state_e : FSM state encoding (IDLE, WAIT, ACK)
//   resp_op_e    : captured operation (read, write, illegal read&&write)
//   LAT_MAX      : largest latency the 4-bit counter can express
package mem_resp_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} resp_state_e;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_ERR} resp_op_e;

    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Controller <-> responder bus.
//   read, write : transaction level indicators, held by the controller until ack
//   addr, wdata : access address / write data
//   ack         : one-cycle completion pulse
//   rdata       : read data, valid in the ack cycle of a read
//   err         : high in the ack cycle of an illegal (read&&write) request
// master = controller side, slave = responder side.
interface mem_responder_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output read, write, addr, wdata,
        input  ack, rdata, err
    );

    modport slave (
        input  read, write, addr, wdata,
        output ack, rdata, err
    );
endinterface

// File: rtl/mem_responder_regfile.sv
// Storage for the responder: 2**ADDR_W words of DATA_W bits held in flops.
//   clk, resetn : clock / asynchronous active-low clear of every word
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port
module mem_resp_regfile #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  word_we;

    // One-hot write enable per word.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
            assign word_we[gi] = we && (waddr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (word_we[i]) begin
                    mem_reg[i] <= wdata;
                end
            end
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/mem_responder.sv
// Target-side responder for the req/we/ack transaction controller.
// Captures a read or write request, waits RD_LAT / WR_LAT cycles from the
// capture cycle, performs the access on the internal register file and
// returns a one-cycle ack (plus err for an illegal read&&write request).
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset; drops any in-flight operation
//   bus    : mem_responder_if slave modport (read/write/addr/wdata in,
//            ack/rdata/err out)
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic            clk,
    input  logic            resetn,
    mem_responder_if.slave  bus
);
    generate
        if (RD_LAT < 1 || RD_LAT > LAT_MAX) begin : g_bad_rd_lat
            $error("mem_responder: RD_LAT must be in 1..15");
        end
        if (WR_LAT < 1 || WR_LAT > LAT_MAX) begin : g_bad_wr_lat
            $error("mem_responder: WR_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] WR_LAT_C = CNT_W'(WR_LAT);

    resp_state_e       state_reg;
    resp_op_e          op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              ack_reg;
    logic              err_reg;
    logic [DATA_W-1:0] rdata_reg;

    resp_op_e          op_in;
    logic [CNT_W-1:0]  lat_in;
    logic              req;
    logic              abort;
    logic              enter_ack;
    resp_op_e          acc_op;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    always_comb begin
        op_in = OP_WR;
        if (bus.read && bus.write) begin
            op_in = OP_ERR;
        end else if (bus.read) begin
            op_in = OP_RD;
        end

        case (op_in)
            OP_RD:   lat_in = RD_LAT_C;
            OP_WR:   lat_in = WR_LAT_C;
            default: lat_in = CNT_W'(1);
        endcase
    end

    assign req   = bus.read || bus.write;
    assign abort = !bus.read && !bus.write;

    // A latency-1 request enters ACK on the capture edge itself, before the
    // capture registers hold anything, so the access uses the live bus
    // values in IDLE and the captured values otherwise.
    assign acc_op    = (state_reg == IDLE) ? op_in     : op_reg;
    assign acc_addr  = (state_reg == IDLE) ? bus.addr  : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? bus.wdata : wdata_reg;

    // Abort wins over an expiring counter: a dropped request never acks.
    assign enter_ack = ((state_reg == IDLE) && req && (lat_in == CNT_W'(1))) ||
                       ((state_reg == WAIT) && !abort && (cnt_reg == '0));

    assign mem_we = enter_ack && (acc_op == OP_WR);

    mem_resp_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk    (clk),
        .resetn (resetn),
        .we     (mem_we),
        .waddr  (acc_addr),
        .wdata  (acc_wdata),
        .raddr  (acc_addr),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            op_reg    <= OP_RD;
            addr_reg  <= '0;
            wdata_reg <= '0;
            cnt_reg   <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (req) begin
                        op_reg    <= op_in;
                        addr_reg  <= bus.addr;
                        wdata_reg <= bus.wdata;
                        if (lat_in == CNT_W'(1)) begin
                            state_reg <= ACK;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= lat_in - CNT_W'(2);
                        end
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == '0) begin
                        state_reg <= ACK;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ACK: begin
                    // Inputs are ignored here; the controller drops its
                    // request on this same edge.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            if (enter_ack) begin
                ack_reg <= 1'b1;
                if (acc_op == OP_RD) begin
                    rdata_reg <= mem_rdata;
                end
                if (acc_op == OP_ERR) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.ack   = ack_reg;
    assign bus.err   = err_reg;
    assign bus.rdata = rdata_reg;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    import mem_resp_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(4), .DATA_W(8)) b0 ();
    mem_responder_if #(.ADDR_W(4), .DATA_W(8)) b4 ();
    mem_responder_if #(.ADDR_W(4), .DATA_W(8)) b3 ();

    mem_responder #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2), .WR_LAT(1)) u0 (
        .clk (clk), .resetn (resetn), .bus (b0)
    );
    mem_responder #(.ADDR_W(4), .DATA_W(8), .RD_LAT(4), .WR_LAT(1)) u4 (
        .clk (clk), .resetn (resetn), .bus (b4)
    );
    mem_responder #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3), .WR_LAT(1)) u3 (
        .clk (clk), .resetn (resetn), .bus (b3)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [3:0] a, input logic [7:0] d);
        case (sel)
            0: begin b0.read = rd; b0.write = wr; b0.addr = a; b0.wdata = d; end
            4: begin b4.read = rd; b4.write = wr; b4.addr = a; b4.wdata = d; end
            default: begin b3.read = rd; b3.write = wr; b3.addr = a; b3.wdata = d; end
        endcase
    endtask

    function automatic logic [31:0] o_ack(input int sel);
        case (sel)
            0:       return 32'(b0.ack);
            4:       return 32'(b4.ack);
            default: return 32'(b3.ack);
        endcase
    endfunction

    function automatic logic [31:0] o_err(input int sel);
        case (sel)
            0:       return 32'(b0.err);
            4:       return 32'(b4.err);
            default: return 32'(b3.err);
        endcase
    endfunction

    function automatic logic [31:0] o_rdata(input int sel);
        case (sel)
            0:       return 32'(b0.rdata);
            4:       return 32'(b4.rdata);
            default: return 32'(b3.rdata);
        endcase
    endfunction

    // Write with WR_LAT=1: ack only in T+1.
    task automatic do_write(input int sel, input logic [3:0] a, input logic [7:0] d, input string tag);
        drive(sel, 1'b0, 1'b1, a, d);
        chk({tag, " ack@T"}, o_ack(sel), 32'd0);
        step();
        chk({tag, " ack@T+1"}, o_ack(sel), 32'd1);
        chk({tag, " err@T+1"}, o_err(sel), 32'd0);
        drive(sel, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        chk({tag, " ack@T+2"}, o_ack(sel), 32'd0);
        $display("write u%0d addr=%0d data=0x%02h", sel, a, d);
    endtask

    // Read: ack exactly at T+lat with the expected data.
    task automatic do_read(input int sel, input logic [3:0] a, input logic [7:0] exp,
                           input int lat, input string tag);
        drive(sel, 1'b1, 1'b0, a, 8'd0);
        for (int k = 1; k < lat; k++) begin
            step();
            chk({tag, " early ack"}, o_ack(sel), 32'd0);
        end
        step();
        chk({tag, " ack"}, o_ack(sel), 32'd1);
        chk({tag, " rdata"}, o_rdata(sel), 32'(exp));
        chk({tag, " err"}, o_err(sel), 32'd0);
        drive(sel, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        chk({tag, " ack after"}, o_ack(sel), 32'd0);
        $display("read  u%0d addr=%0d exp=0x%02h lat=%0d", sel, a, exp, lat);
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
        drive(4, 1'b0, 1'b0, 4'd0, 8'd0);
        drive(3, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        step();
        resetn = 1'b1;
        step();
        chk("reset ack", o_ack(0), 32'd0);
        chk("reset err", o_err(0), 32'd0);
        chk("reset rdata", o_rdata(0), 32'd0);
        $display("reset released");

        // Write then read back, default latencies.
        do_write(0, 4'd5, 8'hA5, "wr5");
        do_read(0, 4'd5, 8'hA5, 2, "rd5");
        step();
        step();
        chk("rdata hold T+5", o_rdata(0), 32'hA5);
        $display("rdata hold check");

        // Reset while a read is in WAIT.
        drive(0, 1'b1, 1'b0, 4'd5, 8'd0);
        step();
        resetn = 1'b0;
        #1;
        chk("async rst ack", o_ack(0), 32'd0);
        chk("async rst err", o_err(0), 32'd0);
        chk("async rst rdata", o_rdata(0), 32'd0);
        step();
        chk("in-reset ack", o_ack(0), 32'd0);
        drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
        resetn = 1'b1;
        step();
        chk("post-rst ack", o_ack(0), 32'd0);
        $display("reset mid-WAIT");
        do_read(0, 4'd3, 8'h00, 2, "rd3 after rst");
        do_read(0, 4'd5, 8'h00, 2, "rd5 after rst");

        // Illegal request after some real data sits in rdata.
        do_write(0, 4'd7, 8'h3C, "wr7");
        do_read(0, 4'd7, 8'h3C, 2, "rd7");
        drive(0, 1'b1, 1'b1, 4'd2, 8'hFF);
        chk("illegal ack@T", o_ack(0), 32'd0);
        step();
        chk("illegal ack", o_ack(0), 32'd1);
        chk("illegal err", o_err(0), 32'd1);
        chk("illegal rdata kept", o_rdata(0), 32'h3C);
        drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        chk("illegal ack after", o_ack(0), 32'd0);
        chk("illegal err after", o_err(0), 32'd0);
        $display("illegal read&&write addr=2");
        do_read(0, 4'd2, 8'h00, 2, "rd2 untouched");

        // Abort with RD_LAT=4.
        do_write(4, 4'd1, 8'h77, "u4 wr1");
        drive(4, 1'b1, 1'b0, 4'd1, 8'd0);
        step();
        drive(4, 1'b0, 1'b0, 4'd0, 8'd0);
        chk("abort ack T+1", o_ack(4), 32'd0);
        for (int k = 2; k <= 8; k++) begin
            step();
            chk($sformatf("abort ack T+%0d", k), o_ack(4), 32'd0);
        end
        chk("abort rdata", o_rdata(4), 32'd0);
        $display("abort RD_LAT=4");
        do_read(4, 4'd1, 8'h77, 4, "u4 rd1 after abort");

        // Address change after capture, RD_LAT=3, read held through ack.
        do_write(3, 4'd5, 8'hC3, "u3 wr5");
        do_write(3, 4'd6, 8'h6C, "u3 wr6");
        drive(3, 1'b1, 1'b0, 4'd5, 8'd0);
        step();
        drive(3, 1'b1, 1'b0, 4'd6, 8'd0);
        chk("stab ack T+1", o_ack(3), 32'd0);
        step();
        chk("stab ack T+2", o_ack(3), 32'd0);
        step();
        chk("stab ack T+3", o_ack(3), 32'd1);
        chk("stab rdata", o_rdata(3), 32'hC3);
        step();
        chk("stab ack T+4", o_ack(3), 32'd0);
        drive(3, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        chk("stab ack T+5", o_ack(3), 32'd0);
        step();
        chk("stab ack T+6", o_ack(3), 32'd0);
        chk("stab rdata hold", o_rdata(3), 32'hC3);
        $display("addr stability RD_LAT=3");
        do_read(3, 4'd6, 8'h6C, 3, "u3 rd6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
